// File: rtl/nx_constants_pkg.sv
// Shared message definitions for the nx mesh: message header, payload and helpers.
package nx_constants;

  localparam int NX_COL_W     = 4;
  localparam int NX_TAG_W     = 8;
  localparam int NX_PAYLOAD_W = 32;

  typedef struct packed {
    logic [NX_TAG_W-1:0] tag;
    logic [NX_COL_W-1:0] col;
  } nx_header_t;

  typedef struct packed {
    nx_header_t              hdr;
    logic [NX_PAYLOAD_W-1:0] payload;
  } nx_message_t;

  localparam int NX_MSG_W = $bits(nx_message_t);

  function automatic logic [NX_COL_W-1:0] nx_col(input nx_message_t m);
    return m.hdr.col;
  endfunction

endpackage

// File: rtl/nx_fifo.sv
// Power-of-two FIFO with combinational read port so a pushed entry is poppable next cycle.
module nx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO may still take a write when the same cycle frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/nx_stream_hub.sv
// Host <-> mesh column stream hub: routes host messages by column, merges column traffic round-robin.
// Optional traffic counters are enabled by defining NX_HUB_STATS_EN.
module nx_stream_hub
  import nx_constants::*;
#(
  parameter int CHANNELS       = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_COL_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  nx_message_t                  host_ib_data_i,
  input  logic                         host_ib_valid_i,
  output logic                         host_ib_ready_o,
  output nx_message_t                  host_ob_data_o,
  output logic                         host_ob_valid_o,
  input  logic                         host_ob_ready_i,
  output nx_message_t [CHANNELS-1:0]   chan_ob_data_o,
  output logic        [CHANNELS-1:0]   chan_ob_valid_o,
  input  logic        [CHANNELS-1:0]   chan_ob_ready_i,
  input  nx_message_t [CHANNELS-1:0]   chan_ib_data_i,
  input  logic        [CHANNELS-1:0]   chan_ib_valid_i,
  output logic        [CHANNELS-1:0]   chan_ib_ready_o,
  output logic                         idle_o
`ifdef NX_HUB_STATS_EN
  ,
  output logic [31:0]                  stat_in_o,
  output logic [31:0]                  stat_out_o,
  output logic [31:0]                  stat_drop_o
`endif
);

  localparam int GRANT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  nx_message_t                route_data_reg;
  logic                       route_valid_reg;
  logic [ADDR_COL_WIDTH-1:0]  route_col;
  logic [CHANNELS-1:0]        route_hit;
  logic                       route_accept;
  logic                       route_drop;
  logic                       host_ib_xfer;

  nx_message_t                ob_data_reg;
  logic                       ob_valid_reg;
  logic                       ob_load;
  logic [GRANT_W-1:0]         start_reg;
  logic [GRANT_W-1:0]         grant_idx;
  logic                       grant_any;

  logic [CHANNELS-1:0]        fifo_full;
  logic [CHANNELS-1:0]        fifo_empty;
  logic [CHANNELS-1:0]        fifo_pop;
  logic [NX_MSG_W-1:0]        fifo_dout [CHANNELS];

  assign route_col    = ADDR_COL_WIDTH'(nx_col(route_data_reg));
  assign route_accept = |(chan_ob_valid_o & chan_ob_ready_i);
  // Out-of-range columns match no channel and are retired one cycle after capture.
  assign route_drop   = route_valid_reg && !(|route_hit);

  assign host_ib_ready_o = !rst_i && (!route_valid_reg || route_accept || route_drop);
  assign host_ib_xfer    = host_ib_valid_i && host_ib_ready_o;

  assign host_ob_valid_o = !rst_i && ob_valid_reg;
  assign host_ob_data_o  = ob_data_reg;
  assign ob_load         = grant_any && (!ob_valid_reg || host_ob_ready_i);

  assign idle_o = rst_i || (!route_valid_reg && !ob_valid_reg && (&fifo_empty));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign route_hit[gi]       = (route_col == ADDR_COL_WIDTH'(gi));
      assign chan_ob_valid_o[gi] = !rst_i && route_valid_reg && route_hit[gi];
      assign chan_ob_data_o[gi]  = route_data_reg;
      assign chan_ib_ready_o[gi] = !rst_i && !fifo_full[gi];
      assign fifo_pop[gi]        = ob_load && (grant_idx == GRANT_W'(gi));

      nx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NX_MSG_W)
      ) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (chan_ib_valid_i[gi] && chan_ib_ready_o[gi]),
        .push_data (chan_ib_data_i[gi]),
        .pop       (fifo_pop[gi]),
        .pop_data  (fifo_dout[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi])
      );
    end
  endgenerate

  // Round-robin search beginning at the channel after the last grant.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(start_reg) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_any && !fifo_empty[idx]) begin
        grant_any = 1'b1;
        grant_idx = GRANT_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      route_valid_reg <= 1'b0;
    end else if (host_ib_xfer) begin
      route_valid_reg <= 1'b1;
      route_data_reg  <= host_ib_data_i;
    end else if (route_accept || route_drop) begin
      route_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ob_valid_reg <= 1'b0;
      start_reg    <= '0;
    end else if (ob_load) begin
      ob_valid_reg <= 1'b1;
      ob_data_reg  <= nx_message_t'(fifo_dout[grant_idx]);
      start_reg    <= (grant_idx == GRANT_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (host_ob_ready_i) begin
      ob_valid_reg <= 1'b0;
    end
  end

`ifdef NX_HUB_STATS_EN
  logic [31:0] stat_in_reg;
  logic [31:0] stat_out_reg;
  logic [31:0] stat_drop_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_in_reg   <= '0;
      stat_out_reg  <= '0;
      stat_drop_reg <= '0;
    end else begin
      if (host_ib_xfer)                       stat_in_reg   <= stat_in_reg + 1'b1;
      if (host_ob_valid_o && host_ob_ready_i) stat_out_reg  <= stat_out_reg + 1'b1;
      if (route_drop)                         stat_drop_reg <= stat_drop_reg + 1'b1;
    end
  end

  assign stat_in_o   = stat_in_reg;
  assign stat_out_o  = stat_out_reg;
  assign stat_drop_o = stat_drop_reg;
`endif

endmodule

// File: tb/tb_nx_stream_hub.sv
// Directed bench for nx_stream_hub: reset, routing, drop, backpressure, FIFO full, reset flush, fairness.
module tb_nx_stream_hub;
  import nx_constants::*;

  localparam int CH = 4;
  localparam int FD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  nx_message_t            host_ib_data;
  logic                   host_ib_valid;
  logic                   host_ib_ready;
  nx_message_t            host_ob_data;
  logic                   host_ob_valid;
  logic                   host_ob_ready;
  nx_message_t [CH-1:0]   chan_ob_data;
  logic        [CH-1:0]   chan_ob_valid;
  logic        [CH-1:0]   chan_ob_ready;
  nx_message_t [CH-1:0]   chan_ib_data;
  logic        [CH-1:0]   chan_ib_valid;
  logic        [CH-1:0]   chan_ib_ready;
  logic                   idle;
`ifdef NX_HUB_STATS_EN
  logic [31:0]            stat_in;
  logic [31:0]            stat_out;
  logic [31:0]            stat_drop;
`endif

  int total_checks  = 0;
  int passed_checks = 0;
  int grant_cnt [CH];

  always #5 clk = ~clk;

  nx_stream_hub #(
    .CHANNELS       (CH),
    .FIFO_DEPTH     (FD),
    .ADDR_COL_WIDTH (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .host_ib_data_i  (host_ib_data),
    .host_ib_valid_i (host_ib_valid),
    .host_ib_ready_o (host_ib_ready),
    .host_ob_data_o  (host_ob_data),
    .host_ob_valid_o (host_ob_valid),
    .host_ob_ready_i (host_ob_ready),
    .chan_ob_data_o  (chan_ob_data),
    .chan_ob_valid_o (chan_ob_valid),
    .chan_ob_ready_i (chan_ob_ready),
    .chan_ib_data_i  (chan_ib_data),
    .chan_ib_valid_i (chan_ib_valid),
    .chan_ib_ready_o (chan_ib_ready),
    .idle_o          (idle)
`ifdef NX_HUB_STATS_EN
    ,
    .stat_in_o       (stat_in),
    .stat_out_o      (stat_out),
    .stat_drop_o     (stat_drop)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic nx_message_t mk(input int col, input int pl);
    nx_message_t m;
    m.hdr.tag = 8'(pl);
    m.hdr.col = NX_COL_W'(col);
    m.payload = 32'(pl);
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    host_ib_data  = '0;
    host_ib_valid = 1'b0;
    host_ob_ready = 1'b0;
    chan_ob_ready = '0;
    chan_ib_data  = '0;
    chan_ib_valid = '0;
    for (int c = 0; c < CH; c++) grant_cnt[c] = 0;

    // Reset state
    step();
    step();
    chk("rst_host_ib_ready", 64'(host_ib_ready), 64'(0));
    chk("rst_chan_ib_ready", 64'(chan_ib_ready), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_host_ob_valid", 64'(host_ob_valid), 64'(0));
    chk("rst_chan_ob_valid", 64'(chan_ob_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_host_ib_ready", 64'(host_ib_ready), 64'(1));
    chk("post_rst_chan_ib_ready", 64'(chan_ib_ready), 64'(4'hf));

    // Route: columns 0..3 back-to-back
    chan_ob_ready = 4'hf;
    step();
    for (int i = 0; i < 4; i++) begin
      host_ib_valid = 1'b1;
      host_ib_data  = mk(i, 32'h100 + i);
      #1;
      if (i > 0) begin
        chk("route_valid", 64'(chan_ob_valid), 64'(4'b0001 << (i - 1)));
        chk("route_payload", 64'(chan_ob_data[i-1].payload), 64'(32'h100 + i - 1));
      end
      chk("route_ib_ready", 64'(host_ib_ready), 64'(1));
      step();
    end
    host_ib_valid = 1'b0;
    #1;
    chk("route_last_valid", 64'(chan_ob_valid), 64'(4'b1000));
    chk("route_last_payload", 64'(chan_ob_data[3].payload), 64'(32'h103));
    step();
    chk("route_done_valid", 64'(chan_ob_valid), 64'(0));
    chk("route_done_idle", 64'(idle), 64'(1));

    // Drop: column 5 discarded, next message routed normally
    host_ib_valid = 1'b1;
    host_ib_data  = mk(5, 32'h55);
    #1;
    chk("drop_accept", 64'(host_ib_ready), 64'(1));
    step();
    host_ib_data = mk(1, 32'h66);
    #1;
    chk("drop_no_valid", 64'(chan_ob_valid), 64'(0));
    chk("drop_next_ready", 64'(host_ib_ready), 64'(1));
    step();
    host_ib_valid = 1'b0;
    #1;
    chk("drop_next_valid", 64'(chan_ob_valid), 64'(4'b0010));
    chk("drop_next_payload", 64'(chan_ob_data[1].payload), 64'(32'h66));
`ifdef NX_HUB_STATS_EN
    chk("stat_drop", 64'(stat_drop), 64'(1));
    chk("stat_in", 64'(stat_in), 64'(6));
    chk("stat_out", 64'(stat_out), 64'(0));
`endif
    step();
    chk("drop_done_valid", 64'(chan_ob_valid), 64'(0));

    // Backpressure on channel 2 holds the route register
    chan_ob_ready = 4'b1011;
    host_ib_valid = 1'b1;
    host_ib_data  = mk(2, 32'h77);
    #1;
    chk("bp_accept", 64'(host_ib_ready), 64'(1));
    step();
    host_ib_valid = 1'b0;
    #1;
    chk("bp_valid", 64'(chan_ob_valid), 64'(4'b0100));
    chk("bp_ib_ready_low", 64'(host_ib_ready), 64'(0));
    step();
    chk("bp_valid_held", 64'(chan_ob_valid), 64'(4'b0100));
    chk("bp_payload_held", 64'(chan_ob_data[2].payload), 64'(32'h77));
    chan_ob_ready = 4'hf;
    #1;
    chk("bp_release_ready", 64'(host_ib_ready), 64'(1));
    step();
    chk("bp_done_valid", 64'(chan_ob_valid), 64'(0));

    // Full: occupy the output register, then fill FIFO 2
    host_ob_ready   = 1'b0;
    chan_ib_valid   = 4'b0001;
    chan_ib_data[0] = mk(0, 32'hA0);
    #1;
    chk("full_pre_ready", 64'(chan_ib_ready[0]), 64'(1));
    step();
    chan_ib_valid = '0;
    step();
    chk("full_pre_ob_valid", 64'(host_ob_valid), 64'(1));
    chk("full_pre_ob_payload", 64'(host_ob_data.payload), 64'(32'hA0));
    for (int k = 0; k < 4; k++) begin
      chan_ib_valid   = 4'b0100;
      chan_ib_data[2] = mk(2, 32'hC0 + k);
      #1;
      chk("full_ready_open", 64'(chan_ib_ready[2]), 64'(1));
      step();
    end
    chan_ib_data[2] = mk(2, 32'hC4);
    #1;
    chk("full_ready_drop", 64'(chan_ib_ready[2]), 64'(0));
    step();
    chk("full_ready_still_low", 64'(chan_ib_ready[2]), 64'(0));
    chk("full_ob_held", 64'(host_ob_data.payload), 64'(32'hA0));
    host_ob_ready = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      chk("full_drain_valid", 64'(host_ob_valid), 64'(1));
      chk("full_drain_payload", 64'(host_ob_data.payload),
          64'((j == 0) ? 32'hA0 : 32'hC0 + j - 1));
      if (j == 1) chk("full_ready_reopen", 64'(chan_ib_ready[2]), 64'(1));
      if (j == 2) chan_ib_valid = '0;
      step();
    end
    chk("full_end_valid", 64'(host_ob_valid), 64'(0));
    chk("full_end_idle", 64'(idle), 64'(1));

    // Reset flush with messages buffered in FIFO 1, output and route registers
    host_ob_ready   = 1'b0;
    chan_ob_ready   = '0;
    chan_ib_valid   = 4'b0010;
    chan_ib_data[1] = mk(1, 32'hB0);
    host_ib_valid   = 1'b1;
    host_ib_data    = mk(3, 32'hD0);
    step();
    step();
    step();
    chan_ib_valid = '0;
    host_ib_valid = 1'b0;
    #1;
    chk("flush_pre_idle", 64'(idle), 64'(0));
    chk("flush_pre_route", 64'(chan_ob_valid), 64'(4'b1000));
    chk("flush_pre_ob", 64'(host_ob_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("flush_in_rst_ob", 64'(host_ob_valid), 64'(0));
    chk("flush_in_rst_chan", 64'(chan_ob_valid), 64'(0));
    chk("flush_in_rst_ib_ready", 64'(host_ib_ready), 64'(0));
    chk("flush_in_rst_chan_ready", 64'(chan_ib_ready), 64'(0));
    chk("flush_in_rst_idle", 64'(idle), 64'(1));
    step();
    rst = 1'b0;
    #1;
    chk("flush_post_idle", 64'(idle), 64'(1));
    chk("flush_post_ob", 64'(host_ob_valid), 64'(0));
    chk("flush_post_chan", 64'(chan_ob_valid), 64'(0));

    // Fairness: all channels continuously valid, first grant to channel 0
    chan_ob_ready = 4'hf;
    host_ob_ready = 1'b1;
    for (int c = 0; c < CH; c++) chan_ib_data[c] = mk(c, 32'hF00 + c);
    chan_ib_valid = 4'hf;
    step();
    step();
    for (int n = 0; n < 400; n++) begin
      chk("fair_grant", 64'({host_ob_valid, host_ob_data.hdr.col}),
          64'({1'b1, 4'(n % 4)}));
      if (host_ob_valid && host_ob_data.hdr.col < 4'(CH)) grant_cnt[host_ob_data.hdr.col]++;
      step();
    end
    for (int c = 0; c < CH; c++) chk("fair_share", 64'(grant_cnt[c]), 64'(100));
    chan_ib_valid = '0;
    for (int w = 0; w < 50 && !idle; w++) step();
    chk("fair_drain_idle", 64'(idle), 64'(1));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
